// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory write buffer.
package mem_ctrl_pkg;

   // Default number of write-buffer entries (power of two, at least 2).
   localparam int DEFAULT_DEPTH = 4;

   // Field width of a stored entry; the block's WIDTH must not exceed this.
   localparam int ENTRY_WIDTH = 32;

   // Controller states: idle, draining the head store, reading on a load miss,
   // and presenting the returned load data for one cycle.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // One buffered store.
   typedef struct packed {
      logic                   valid;
      logic [ENTRY_WIDTH-1:0] addr;
      logic [ENTRY_WIDTH-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-buffer FIFO: circular storage of pending stores with head/tail
// pointers and an occupancy count. Every entry is exposed so the owner can
// perform the load-forwarding compare against all of them.
module wb_fifo
   import mem_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_addr,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH)-1:0]   head,
   output wb_entry_t                  entries [DEPTH]
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]    count;
   logic [PW-1:0]  tail;
   logic           do_push;
   logic           do_pop;
   logic [DEPTH-1:0] slot_load;
   logic [DEPTH-1:0] slot_clear;

   // Full is judged on the registered count only, so a drain completing in the
   // same cycle never lets a store slip into a full buffer.
   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Per-slot write and invalidate strobes decoded from the pointers.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_load[gi]  = do_push && (tail == PW'(gi));
      assign slot_clear[gi] = do_pop && (head == PW'(gi));
   end

   // Entry storage: load at tail on push, drop the valid bit at head on pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (slot_clear[i]) begin
               entries[i].valid <= 1'b0;
            end
            if (slot_load[i]) begin
               entries[i] <= '{valid: 1'b1,
                               addr:  ENTRY_WIDTH'(push_addr),
                               data:  ENTRY_WIDTH'(push_data)};
            end
         end
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; simultaneous
   // push and pop leave the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            tail <= tail + 1'b1;
         end
         if (do_pop) begin
            head <= head + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/data_mem_buffer.sv
// Data-memory front end: buffers CPU stores, forwards loads from the buffer,
// and sequences RAM accesses (drains and load misses) with a small FSM.
module data_mem_buffer
   import mem_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] MEM_ADDR,
   input  logic             WRITE_MEM_EN,
   input  logic [WIDTH-1:0] WRITE_MEM_DATA,
   input  logic             READ_MEM_EN,
   output logic [WIDTH-1:0] READ_MEM_DATA,
   output logic             STALL,
   output logic             RAM_REQ,
   output logic             RAM_WE,
   output logic [WIDTH-1:0] RAM_ADDR,
   output logic [WIDTH-1:0] RAM_WDATA,
   input  logic             RAM_ACK,
   input  logic [WIDTH-1:0] RAM_RDATA
);

   localparam int PW = $clog2(DEPTH);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] rdata_q;
   logic             store;
   logic             load;
   logic             match;
   logic             hit;
   logic             miss;
   logic             pop;
   logic             full;
   logic             empty;
   logic             stall;
   logic [PW-1:0]    head;
   logic [PW-1:0]    idx;
   logic [WIDTH-1:0] fwd_data;
   logic [WIDTH-1:0] rd_data;
   wb_entry_t        entries [DEPTH];

   // A simultaneous store and load is treated as a store only.
   assign store = WRITE_MEM_EN;
   assign load  = READ_MEM_EN & ~WRITE_MEM_EN;
   assign hit   = load & match;
   assign miss  = load & ~match;

   wb_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RESET),
      .push      (store),
      .push_addr (MEM_ADDR),
      .push_data (WRITE_MEM_DATA),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .head      (head),
      .entries   (entries)
   );

   // Forwarding compare: walk entries oldest to youngest so the last match,
   // i.e. the youngest store to this address, wins.
   always_comb begin
      match    = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (entries[idx].valid && (WIDTH'(entries[idx].addr) == MEM_ADDR)) begin
            match    = 1'b1;
            fwd_data = WIDTH'(entries[idx].data);
         end
      end
   end

   // State register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Capture RAM read data when a load-miss read completes.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rdata_q <= '0;
      end else if ((state == READ) && RAM_ACK) begin
         rdata_q <= RAM_RDATA;
      end
   end

   // Next state, RAM request signals, stall and load data selection.
   always_comb begin
      next_state = state;
      stall      = 1'b0;
      pop        = 1'b0;
      RAM_REQ    = 1'b0;
      RAM_WE     = 1'b0;
      RAM_ADDR   = '0;
      RAM_WDATA  = '0;
      rd_data    = '0;
      case (state)
         IDLE: begin
            stall = miss;
            if (miss) begin
               next_state = READ;
            end else if (!empty) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            stall     = miss;
            RAM_REQ   = 1'b1;
            RAM_WE    = 1'b1;
            RAM_ADDR  = WIDTH'(entries[head].addr);
            RAM_WDATA = WIDTH'(entries[head].data);
            if (RAM_ACK) begin
               pop        = 1'b1;
               next_state = IDLE;
            end
         end
         READ: begin
            stall    = 1'b1;
            RAM_REQ  = 1'b1;
            RAM_ADDR = MEM_ADDR;
            if (RAM_ACK) begin
               next_state = RESP;
            end
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (store && full) begin
         stall = 1'b1;
      end
      if ((state == RESP) && load) begin
         rd_data = rdata_q;
      end else if (hit) begin
         rd_data = fwd_data;
      end
   end

   // CPU-facing outputs are forced low while reset is held, even if the CPU
   // presents a load during reset.
   assign STALL         = stall & ~RESET;
   assign READ_MEM_DATA = RESET ? '0 : rd_data;

endmodule

// File: doc/data_mem_buffer.md
DATA_MEM_BUFFER -- requirements
Module: data_mem_buffer

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-002 Parameters SHALL be:
- WIDTH, 32, data and address width.
- DEPTH, 4, write-buffer entries (power of two, at least 2).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high.
- MEM_ADDR  in  WIDTH  CPU data address (CPU MEM stage).
- WRITE_MEM_EN  in  1  CPU store request.
- WRITE_MEM_DATA  in  WIDTH  CPU store data.
- READ_MEM_EN  in  1  CPU load request.
- READ_MEM_DATA  out  WIDTH  load data to the CPU.
- STALL  out  1  CPU must hold its MEM-stage inputs stable.
- RAM_REQ  out  1  RAM access request.
- RAM_WE  out  1  RAM write (1) or read (0).
- RAM_ADDR  out  WIDTH  RAM address.
- RAM_WDATA  out  WIDTH  RAM write data.
- RAM_ACK  in  1  RAM completion, one-cycle pulse.
- RAM_RDATA  in  WIDTH  RAM read data, valid when RAM_ACK=1.

Function
REQ-004 The block SHALL implement a FIFO write buffer of DEPTH entries, each holding {valid, addr, data}, plus an occupancy count.
REQ-005 Store accept: when WRITE_MEM_EN=1 and count<DEPTH, the block SHALL enqueue {MEM_ADDR, WRITE_MEM_DATA} at the clock edge with STALL=0.
REQ-006 Store full: when WRITE_MEM_EN=1 and count==DEPTH (registered count), the block SHALL assert STALL and SHALL NOT enqueue. A same-cycle drain does not bypass the full condition.
REQ-007 Load forwarding: when READ_MEM_EN=1 and MEM_ADDR matches any valid entry (full-word compare), READ_MEM_DATA SHALL combinationally equal the youngest matching entry's data, with STALL=0.
REQ-008 Load miss: a load with no match SHALL assert STALL in the same cycle and go to RAM.
REQ-009 The FSM states SHALL be IDLE, DRAIN, READ and RESP:
- IDLE -> READ on a load miss, with priority over draining.
- IDLE -> DRAIN when count>0 and there is no load miss.
- DRAIN -> IDLE on RAM_ACK, which dequeues the head.
- READ -> RESP on RAM_ACK, which captures RAM_RDATA into rdata_q.
- RESP -> IDLE unconditionally.
REQ-010 STALL SHALL be 1 in every cycle of a pending load miss:
- in IDLE on the miss, while in DRAIN with a load miss waiting, and throughout READ.
- STALL SHALL be 0 in RESP, where READ_MEM_DATA=rdata_q.
- Minimum load-miss latency: request cycle plus RAM latency plus 1.
REQ-011 In DRAIN, RAM_REQ=1 and RAM_WE=1, with RAM_ADDR and RAM_WDATA equal to the head entry, held stable until RAM_ACK.
REQ-012 In READ, RAM_REQ=1 and RAM_WE=0, with RAM_ADDR=MEM_ADDR held stable until RAM_ACK.
REQ-013 RAM_REQ SHALL be 0 in IDLE and RESP, so consecutive requests are separated by at least one idle cycle.
REQ-014 Stores are accepted (REQ-005) in any state, including while a drain is in flight.
REQ-015 Enqueue and dequeue in the same cycle SHALL leave count unchanged.
REQ-016 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-017 WRITE_MEM_EN and READ_MEM_EN asserted together is illegal. The block SHALL treat it as a store and ignore the load.
REQ-018 RAM_ACK received in IDLE or RESP SHALL be ignored.
REQ-019 READ_MEM_DATA SHALL be 0 when no load is being served.

Reset
REQ-020 RESET=1 SHALL asynchronously apply all of the following:
- FSM -> IDLE.
- count, head and tail -> 0; all valid bits -> 0.
- rdata_q -> 0.
- STALL, RAM_REQ and RAM_WE -> 0.
- RAM_ADDR, RAM_WDATA and READ_MEM_DATA -> 0.
REQ-021 Reset mid-operation SHALL discard all buffered stores and abandon any in-flight RAM access. Operation SHALL resume on the first rising edge after RESET deasserts.

Structure
REQ-022 The shared package mem_ctrl_pkg SHALL hold:
- the FSM state enum (IDLE, DRAIN, READ, RESP);
- the buffer-entry struct type;
- the default DEPTH constant.
REQ-023 Buffer storage and pointers SHALL live in one sub-module, wb_fifo. It SHALL expose all entries for the forwarding compare.
REQ-024 The FSM and forwarding mux SHALL reside in data_mem_buffer.

Verification
REQ-025 Store then forward: store 0x10<-0xAAAA5555, load 0x10 the next cycle -> READ_MEM_DATA=0xAAAA5555 with STALL=0 and no RAM read.
REQ-026 Youngest match: stores 0x20<-1 then 0x20<-2 (RAM ACK withheld), load 0x20 -> data=2.
REQ-027 Full: with ACK withheld, five stores 0x0,0x4,0x8,0xC,0x10 -> the fifth sees STALL=1 until the first ACK, then enqueues. RAM receives the writes in order 0x0 through 0x10.
REQ-028 Load miss: empty buffer, load 0x40, RAM ACKs 3 cycles later with 0x12345678 -> STALL high for 4 cycles, then one cycle with STALL=0 and data=0x12345678.
REQ-029 Load during drain: drain of 0x0 in flight, load 0x80 -> the load waits for the drain ACK, then issues RAM_WE=0 to 0x80 before draining the remaining entries.
REQ-030 Reset mid-drain: three entries buffered, RESET pulsed during DRAIN -> all outputs 0 immediately; a later load 0x0 misses to RAM.
